// File: rtl/gf_pkg.sv
// Shared constants and FSM state type for the GF(2^m) multiplier operand loader.
package gf_pkg;

  localparam int unsigned NUM_BITS  = 163;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned OP_W      = NUM_BITS + 1;
  localparam int unsigned NUM_WORDS = (OP_W + WORD_W - 1) / WORD_W;
  localparam int unsigned IN_CNT_W  = $clog2(2 * NUM_WORDS);
  localparam int unsigned OUT_CNT_W = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    UNLOAD = 2'd3
  } state_e;

endpackage

// File: rtl/gf_mult_loader.sv
// Word-serial host bridge for a GF(2^m) multiplier: packs two operands from host
// words, launches the multiplier, then streams the product back word by word.
module gf_mult_loader #(
  parameter int unsigned NUM_BITS = gf_pkg::NUM_BITS,
  parameter int unsigned WORD_W   = gf_pkg::WORD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [WORD_W-1:0]   in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic [NUM_BITS:0]   mult_a,
  output logic [NUM_BITS:0]   mult_b,
  output logic                mult_start,
  input  logic [NUM_BITS:0]   mult_product,
  input  logic                mult_done,
  output logic                busy
);
  import gf_pkg::*;

  localparam int unsigned OPND_W  = NUM_BITS + 1;
  localparam int unsigned N_WORDS = (OPND_W + WORD_W - 1) / WORD_W;
  localparam int unsigned ICNT_W  = $clog2(2 * N_WORDS);
  localparam int unsigned OCNT_W  = $clog2(N_WORDS);

  state_e              state_q, state_d;
  logic [ICNT_W-1:0]   in_cnt_q, in_cnt_d;
  logic [OCNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [OPND_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                start_q, start_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [WORD_W-1:0]   out_data_q, out_data_d;
  logic                in_hs, out_hs;
  logic [ICNT_W-1:0]   load_idx;
  logic [OPND_W-1:0]   word_ext, word_mask;

  assign in_hs  = in_valid & in_ready_q;
  assign out_hs = out_valid_q & out_ready;

  // Position the incoming word; bits beyond the operand top fall off the shift.
  always_comb begin
    load_idx  = (in_cnt_q < ICNT_W'(N_WORDS)) ? in_cnt_q : in_cnt_q - ICNT_W'(N_WORDS);
    word_ext  = OPND_W'(in_data) << (32'(load_idx) * WORD_W);
    word_mask = OPND_W'({WORD_W{1'b1}}) << (32'(load_idx) * WORD_W);
  end

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    in_ready_d  = 1'b1;
    busy_d      = 1'b0;
    start_d     = 1'b0;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_data_d  = '0;

    case (state_q)
      LOAD: begin
        if (in_hs) begin
          if (in_cnt_q < ICNT_W'(N_WORDS)) begin
            a_d = (a_q & ~word_mask) | word_ext;
          end else begin
            b_d = (b_q & ~word_mask) | word_ext;
          end
          if (in_cnt_q == ICNT_W'(2 * N_WORDS - 1)) begin
            in_cnt_d = '0;
            state_d  = START;
          end else begin
            in_cnt_d = in_cnt_q + ICNT_W'(1);
          end
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (mult_done) begin
          res_d     = mult_product;
          out_cnt_d = '0;
          state_d   = UNLOAD;
        end
      end
      UNLOAD: begin
        if (out_hs) begin
          if (out_cnt_q == OCNT_W'(N_WORDS - 1)) begin
            out_cnt_d = '0;
            state_d   = LOAD;
          end else begin
            out_cnt_d = out_cnt_q + OCNT_W'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase

    // Outputs are registered, so they are decoded from the upcoming state.
    in_ready_d  = (state_d == LOAD);
    busy_d      = (state_d != LOAD);
    start_d     = (state_d == START);
    out_valid_d = (state_d == UNLOAD);
    out_last_d  = out_valid_d && (out_cnt_d == OCNT_W'(N_WORDS - 1));
    if (out_valid_d) begin
      out_data_d = WORD_W'(res_d >> (32'(out_cnt_d) * WORD_W));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign mult_start = start_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_data   = out_data_q;
  assign mult_a     = a_q;
  assign mult_b     = b_q;

endmodule

// File: tb/tb_gf_mult_loader.sv
// Self-checking bench for gf_mult_loader with a word-level operand/result model.
module tb_gf_mult_loader;

  localparam int unsigned OW = 164;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_data;
  logic          out_last;
  logic          out_ready = 1'b0;
  logic [OW-1:0] mult_a, mult_b;
  logic          mult_start;
  logic [OW-1:0] mult_product = '0;
  logic          mult_done = 1'b0;
  logic          busy;

  int            checks = 0;
  int            passed = 0;
  logic [31:0]   words[12];
  logic [OW-1:0] exp_a, exp_b;

  always #5 clk = ~clk;

  gf_mult_loader dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .mult_a(mult_a), .mult_b(mult_b), .mult_start(mult_start),
    .mult_product(mult_product), .mult_done(mult_done), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Operand = sum of word[i] * 2^(32*i), reduced to 164 bits.
  function automatic logic [OW-1:0] model_op(int base);
    logic [OW-1:0] v = '0;
    for (int i = 0; i < 6; i++) v = v | (OW'(words[base+i]) << (32 * i));
    return v;
  endfunction

  function automatic logic [31:0] model_word(logic [OW-1:0] p, int i);
    logic [OW-1:0] s = p >> (32 * i);
    return s[31:0];
  endfunction

  function automatic logic [OW-1:0] rand_op();
    logic [191:0] t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[OW-1:0];
  endfunction

  task automatic rand_words();
    for (int i = 0; i < 12; i++) words[i] = $urandom();
  endtask

  // Feeds words[first..11]; checks the single-cycle start pulse after the last handshake.
  task automatic drive_load(input bit gaps, input int first, input bit done_in_start);
    int hs = first;
    int cyc = 0;
    bit tog = 1'b0;
    while (hs < 12 && cyc < 200) begin
      in_valid = gaps ? tog : 1'b1;
      in_data  = in_valid ? words[hs] : $urandom();
      checks++;
      if (in_ready !== 1'b1 || mult_start !== 1'b0 || busy !== 1'b0)
        $display("FAIL load_phase: in_ready=%b mult_start=%b busy=%b, expected 1/0/0", in_ready, mult_start, busy);
      else passed++;
      if (in_valid && in_ready === 1'b1) hs++;
      tick();
      tog = ~tog;
      cyc++;
    end
    checks++;
    if (hs != 12) $display("FAIL load_timeout: handshakes=%0d expected 12", hs);
    else passed++;
    in_valid = 1'b1;
    in_data  = $urandom();
    if (done_in_start) begin
      mult_done    = 1'b1;
      mult_product = rand_op();
    end
    checks++;
    if (mult_start !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL start_pulse: mult_start=%b in_ready=%b busy=%b, expected 1/0/1", mult_start, in_ready, busy);
    else passed++;
    tick();
    mult_done = 1'b0;
    checks++;
    if (mult_start !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL start_one_cycle: mult_start=%b in_ready=%b busy=%b out_valid=%b, expected 0/0/1/0",
               mult_start, in_ready, busy, out_valid);
    else passed++;
  endtask

  // From WAIT: deliver the product after `delay` idle cycles and drain all six words.
  task automatic finish_txn(input logic [OW-1:0] prod, input int delay, input int stall);
    logic [31:0] w;
    int st;
    for (int d = 0; d < delay; d++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL wait_hold: out_valid=%b in_ready=%b busy=%b, expected 0/0/1", out_valid, in_ready, busy);
      else passed++;
    end
    mult_product = prod;
    mult_done    = 1'b1;
    tick();
    mult_done    = 1'b0;
    mult_product = rand_op();
    for (int i = 0; i < 6; i++) begin
      w  = model_word(prod, i);
      st = (stall >= 0) ? stall : int'($urandom_range(0, 2));
      out_ready = 1'b0;
      for (int s = 0; s <= st; s++) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== w || out_last !== (i == 5))
          $display("FAIL unload_word%0d: valid=%b data=%h last=%b, expected 1/%h/%b",
                   i, out_valid, out_data, out_last, w, (i == 5));
        else passed++;
        if (s < st) tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_last !== 1'b0 || out_data !== 32'h0)
      $display("FAIL unload_end: valid=%b ready=%b busy=%b last=%b data=%h, expected 0/1/0/0/0",
               out_valid, in_ready, busy, out_last, out_data);
    else passed++;
    checks++;
    if (mult_a !== exp_a || mult_b !== exp_b)
      $display("FAIL operands_stable: a=%h b=%h, expected %h %h", mult_a, mult_b, exp_a, exp_b);
    else passed++;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_data  = $urandom();
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || mult_start !== 1'b0 ||
        out_last !== 1'b0 || out_data !== 32'h0 || mult_a !== '0 || mult_b !== '0)
      $display("FAIL reset_hold: ready=%b busy=%b valid=%b start=%b last=%b data=%h a=%h b=%h",
               in_ready, busy, out_valid, mult_start, out_last, out_data, mult_a, mult_b);
    else passed++;
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || mult_start !== 1'b0 ||
        out_data !== 32'h0 || mult_a !== '0 || mult_b !== '0)
      $display("FAIL reset_release: ready=%b busy=%b valid=%b start=%b data=%h a=%h b=%h",
               in_ready, busy, out_valid, mult_start, out_data, mult_a, mult_b);
    else passed++;
  endtask

  task automatic test_load(input bit gaps);
    logic [OW-1:0] ea = 164'h10101010000;
    logic [OW-1:0] eb = 164'h50005000;
    for (int i = 0; i < 12; i++) words[i] = 32'h0;
    words[0] = 32'h01010000;
    words[1] = 32'h00000101;
    words[6] = 32'h50005000;
    exp_a = model_op(0);
    exp_b = model_op(6);
    drive_load(gaps, 0, 1'b0);
    checks++;
    if (mult_a !== ea || mult_b !== eb)
      $display("FAIL load_vector(gaps=%0d): a=%h b=%h, expected %h %h", gaps, mult_a, mult_b, ea, eb);
    else passed++;
    finish_txn(rand_op(), 1, 0);
  endtask

  task automatic test_mask();
    logic [OW-1:0] ea = OW'(4'hF) << 160;
    for (int i = 0; i < 12; i++) words[i] = 32'h0;
    words[5] = 32'hFFFFFFFF;
    exp_a = model_op(0);
    exp_b = model_op(6);
    drive_load(1'b0, 0, 1'b0);
    checks++;
    if (mult_a !== ea || mult_b !== '0)
      $display("FAIL mask_top_word: a=%h b=%h, expected %h 0", mult_a, mult_b, ea);
    else passed++;
    finish_txn(rand_op(), 0, 0);
  endtask

  task automatic test_unload();
    logic [OW-1:0] prod = (OW'(4'h8) << 160) | OW'(1);
    rand_words();
    exp_a = model_op(0);
    exp_b = model_op(6);
    drive_load(1'b0, 0, 1'b0);
    finish_txn(prod, 2, 3);
  endtask

  task automatic test_done_ignored();
    logic [OW-1:0] prod = rand_op();
    rand_words();
    exp_a = model_op(0);
    exp_b = model_op(6);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = words[k];
      tick();
    end
    in_valid     = 1'b0;
    mult_done    = 1'b1;
    mult_product = rand_op();
    tick();
    mult_done = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || mult_start !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL done_in_load: ready=%b busy=%b start=%b valid=%b, expected 1/0/0/0",
               in_ready, busy, mult_start, out_valid);
    else passed++;
    drive_load(1'b0, 3, 1'b1);
    checks++;
    if (mult_a !== exp_a || mult_b !== exp_b)
      $display("FAIL split_load: a=%h b=%h, expected %h %h", mult_a, mult_b, exp_a, exp_b);
    else passed++;
    finish_txn(prod, 0, -1);
  endtask

  task automatic test_reset_unload();
    logic [OW-1:0] prod = rand_op();
    rand_words();
    exp_a = model_op(0);
    exp_b = model_op(6);
    drive_load(1'b0, 0, 1'b0);
    mult_product = prod;
    mult_done    = 1'b1;
    tick();
    mult_done = 1'b0;
    in_valid  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== model_word(prod, i))
        $display("FAIL pre_reset_word%0d: valid=%b data=%h, expected 1/%h", i, out_valid, out_data, model_word(prod, i));
      else passed++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_last !== 1'b0 || out_data !== 32'h0)
      $display("FAIL reset_mid_unload: valid=%b ready=%b busy=%b last=%b data=%h, expected 0/1/0/0/0",
               out_valid, in_ready, busy, out_last, out_data);
    else passed++;
    tick();
    rst = 1'b0;
    mult_done    = 1'b1;
    mult_product = rand_op();
    tick();
    mult_done = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || mult_a !== '0)
      $display("FAIL late_done: valid=%b ready=%b busy=%b a=%h, expected 0/1/0/0", out_valid, in_ready, busy, mult_a);
    else passed++;
    rand_words();
    exp_a = model_op(0);
    exp_b = model_op(6);
    drive_load(1'b0, 0, 1'b0);
    finish_txn(rand_op(), 1, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      rand_words();
      exp_a = model_op(0);
      exp_b = model_op(6);
      drive_load(bit'($urandom_range(0, 1)), 0, 1'b0);
      checks++;
      if (mult_a !== exp_a || mult_b !== exp_b)
        $display("FAIL random_operands%0d: a=%h b=%h, expected %h %h", it, mult_a, mult_b, exp_a, exp_b);
      else passed++;
      finish_txn(rand_op(), int'($urandom_range(0, 4)), -1);
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    test_reset();
    test_load(1'b0);
    test_load(1'b1);
    test_mask();
    test_unload();
    test_done_ignored();
    test_reset_unload();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
